// File: rtl/reg_file_bus_param.sv
// rtl/reg_file_bus_param.sv - bus-mapped register file, one strobed write port, two registered read ports
// Write-first forwarding per byte lane, range-hit flags, write error pulses and a one-word-per-cycle clear sweep.
module reg_file_bus_param #(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'('h0100)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     W_addr,
  input  logic [DATA_W-1:0]     wData,
  input  logic [DATA_W/8-1:0]   wStrb,
  input  logic [ADDR_W-1:0]     R_addr2,
  input  logic [ADDR_W-1:0]     R_addr3,
  output logic [DATA_W-1:0]     rData,
  output logic [DATA_W-1:0]     rData2,
  output logic                  rHit,
  output logic                  rHit2,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  wr_err
);

  localparam int NB    = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST    = PTR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [PTR_W-1:0]  ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  // Offset is taken at ADDR_W bits; the >= guard stops low addresses wrapping into the window.
  function automatic logic in_win(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < DEPTH_A);
  endfunction

  function automatic logic [PTR_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return off[PTR_W-1:0];
  endfunction

  logic              w_hit, a_hit, b_hit, w_ok, w_rej;
  logic [PTR_W-1:0]  w_idx, a_idx, b_idx;
  logic [DATA_W-1:0] w_merged, a_next, b_next;

  assign w_hit = in_win(W_addr);
  assign a_hit = in_win(R_addr2);
  assign b_hit = in_win(R_addr3);
  assign w_idx = to_idx(W_addr);
  assign a_idx = to_idx(R_addr2);
  assign b_idx = to_idx(R_addr3);
  assign w_ok  = we && w_hit && (state == IDLE);
  assign w_rej = we && (!w_hit || (state == CLEAR));

  always_comb begin
    w_merged = mem[w_idx];
    for (int i = 0; i < NB; i++) begin
      if (wStrb[i]) w_merged[8*i +: 8] = wData[8*i +: 8];
    end
  end

  // Read data reflects the word as it will be after this edge: sweep zero, then write merge.
  always_comb begin
    a_next = '0;
    if (a_hit) begin
      if ((state == CLEAR) && (a_idx == ptr)) a_next = '0;
      else if (w_ok && (a_idx == w_idx))      a_next = w_merged;
      else                                    a_next = mem[a_idx];
    end
  end

  always_comb begin
    b_next = '0;
    if (b_hit) begin
      if ((state == CLEAR) && (b_idx == ptr)) b_next = '0;
      else if (w_ok && (b_idx == w_idx))      b_next = w_merged;
      else                                    b_next = mem[b_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      state    <= IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      rData    <= '0;
      rData2   <= '0;
      rHit     <= 1'b0;
      rHit2    <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      if (w_ok) mem[w_idx] <= w_merged;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          mem[ptr] <= '0;
          if (ptr == LAST) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end else begin
            ptr <= ptr + PTR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      rData  <= a_next;
      rData2 <= b_next;
      rHit   <= a_hit;
      rHit2  <= b_hit;
      wr_err <= w_rej;
    end
  end

endmodule

// File: tb/tb_reg_file_bus_param.sv
// tb/tb_reg_file_bus_param.sv - directed self-checking bench for reg_file_bus_param
module tb_reg_file_bus_param;

  logic        clk = 1'b0;
  logic        reset, we, clr_req;
  logic [15:0] W_addr, R_addr2, R_addr3;
  logic [63:0] wData;
  logic [7:0]  wStrb;
  logic [63:0] rData, rData2;
  logic        rHit, rHit2, clr_busy, wr_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [63:0] model [12];

  always #5 clk = ~clk;

  reg_file_bus_param dut (
    .clk(clk), .reset(reset), .we(we), .W_addr(W_addr), .wData(wData), .wStrb(wStrb),
    .R_addr2(R_addr2), .R_addr3(R_addr3), .rData(rData), .rData2(rData2),
    .rHit(rHit), .rHit2(rHit2), .clr_req(clr_req), .clr_busy(clr_busy), .wr_err(wr_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] s);
    we = 1'b1; W_addr = a; wData = d; wStrb = s;
    step();
    we = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < 12; k++) begin
      R_addr2 = 16'h0100 + 16'(k);
      R_addr3 = 16'h010B - 16'(k);
      step();
      check($sformatf("%s_a%0d", tag, k), rData, model[k]);
      check($sformatf("%s_b%0d", tag, k), rData2, model[11-k]);
      check($sformatf("%s_hit%0d", tag, k), {62'd0, rHit, rHit2}, 64'd3);
    end
  endtask

  task automatic fill(input logic [63:0] seed);
    for (int k = 0; k < 12; k++) begin
      model[k] = seed ^ {32'(k), 32'(k * 7 + 1)};
      wr(16'h0100 + 16'(k), model[k], 8'hFF);
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1; we = 1'b0; clr_req = 1'b0;
    W_addr = '0; R_addr2 = '0; R_addr3 = '0; wData = '0; wStrb = '0;
    for (int k = 0; k < 12; k++) model[k] = '0;
    step();
    step();
    check("rst_rdata", rData, 64'd0);
    check("rst_rhit", {63'd0, rHit}, 64'd0);
    check("rst_wr_err", {63'd0, wr_err}, 64'd0);
    check("rst_clr_busy", {63'd0, clr_busy}, 64'd0);
    reset = 1'b0;

    // T1: all words zero after reset, whole window hits
    read_all("t1");

    // T2: write/read, port B runs one word ahead and falls off the window at 0x010C
    for (int k = 0; k < 12; k++) begin
      model[k] = 64'hFFFF_FFFF_FF00_FF00 + 64'(k);
      wr(16'h0100 + 16'(k), model[k], 8'hFF);
    end
    for (int k = 0; k < 12; k++) begin
      R_addr2 = 16'h0100 + 16'(k);
      R_addr3 = 16'h0101 + 16'(k);
      step();
      check($sformatf("t2_a%0d", k), rData, 64'hFFFF_FFFF_FF00_FF00 + 64'(k));
      check($sformatf("t2_b%0d", k), rData2, (k == 11) ? 64'd0 : 64'hFFFF_FFFF_FF00_FF00 + 64'(k + 1));
      check($sformatf("t2_hb%0d", k), {63'd0, rHit2}, (k == 11) ? 64'd0 : 64'd1);
    end

    // T3: byte strobes, then an all-zero strobe is a legal no-op
    wr(16'h0102, 64'h1111_1111_1111_1111, 8'hFF);
    wr(16'h0102, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    model[2] = 64'h1111_1111_AAAA_AAAA;
    wr(16'h0102, 64'h5555_5555_5555_5555, 8'h00);
    check("t3_nostrb_err", {63'd0, wr_err}, 64'd0);
    R_addr2 = 16'h0102;
    step();
    check("t3_strb", rData, 64'h1111_1111_AAAA_AAAA);

    // T4: write-first forwarding on both ports
    R_addr2 = 16'h0105; R_addr3 = 16'h0105;
    wr(16'h0105, 64'h1234, 8'hFF);
    model[5] = 64'h1234;
    check("t4_fwd_a", rData, 64'h1234);
    check("t4_fwd_b", rData2, 64'h1234);

    // T5: out-of-window writes below and above the window
    R_addr2 = 16'h00FF;
    wr(16'h00FF, 64'hDEAD, 8'hFF);
    check("t5_err_lo", {63'd0, wr_err}, 64'd1);
    check("t5_hit_lo", {63'd0, rHit}, 64'd0);
    step();
    check("t5_err_lo_end", {63'd0, wr_err}, 64'd0);
    wr(16'h010C, 64'hBEEF, 8'hFF);
    check("t5_err_hi", {63'd0, wr_err}, 64'd1);
    step();
    check("t5_err_hi_end", {63'd0, wr_err}, 64'd0);
    read_all("t5");

    // T6: clear sweep with a rejected mid-sweep write
    fill(64'hA5A5_0000_5A5A_0000);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    cnt = clr_busy ? 1 : 0;
    R_addr2 = 16'h0100; R_addr3 = 16'h010B;
    step();
    if (clr_busy) cnt++;
    check("t6_rd_clearing", rData, 64'd0);
    check("t6_rd_unswept", rData2, model[11]);
    wr(16'h0103, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    if (clr_busy) cnt++;
    check("t6_mid_err", {63'd0, wr_err}, 64'd1);
    for (int i = 0; i < 40 && clr_busy; i++) begin
      step();
      if (clr_busy) cnt++;
    end
    check("t6_busy_cycles", 64'(cnt), 64'd12);
    for (int k = 0; k < 12; k++) model[k] = '0;
    read_all("t6");

    // T6b: reset aborts a sweep at cycle 5
    fill(64'h0123_4567_89AB_CDEF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("t6_busy_pre_rst", {63'd0, clr_busy}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_busy_rst", {63'd0, clr_busy}, 64'd0);
    check("t6_err_rst", {63'd0, wr_err}, 64'd0);
    for (int k = 0; k < 12; k++) model[k] = '0;
    read_all("t6r");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
